rx_train_sequencer: RTL and testbench

RX_TRAIN_SEQUENCER -- requirements
Module: rx_train_sequencer

---
 rtl/rx_train_seq_pkg.sv | 21 ++
 rtl/rx_train_seq_timer.sv | 39 +++
 rtl/rx_train_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_rx_train_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_train_seq_pkg.sv
// rtl/rx_train_seq_pkg.sv - shared state encodings and constants for the rx training sequencer
//
// Purpose: state encoding seen on train_state_o and the retry counter width and
// saturation value, shared by the sequencer top and its timer.
// Ports:   none (package).
package rx_train_seq_pkg;

    localparam int RETRY_CNT_W = 4;
    localparam logic [RETRY_CNT_W-1:0] RETRY_CNT_SAT = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOCK_WAIT = 3'd1,
        ST_CLK_TRAIN = 3'd2,
        ST_BIT_TRAIN = 3'd3,
        ST_DONE      = 3'd4,
        ST_RETRY     = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

endpackage

// File: rtl/rx_train_seq_timer.sv
// rtl/rx_train_seq_timer.sv - loadable down-counter with zero flag
//
// Purpose: single counter shared by the lock-stable wait and the per-phase
// training timeout. Load has priority over decrement; decrement stops at zero.
// Ports:
//   clk_i       sole clock, rising edge
//   rst_i       asynchronous active-high reset, clears the count
//   load_i      load load_val_i this cycle
//   load_val_i  value to load
//   dec_i       decrement by one (ignored when already zero)
//   zero_o      count is zero
module rx_train_seq_timer
    import rx_train_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/rx_train_sequencer.sv
// rtl/rx_train_sequencer.sv - rx lane training sequencer (lock wait, clock align, bit align, retry)
//
// Purpose: waits for a stable PLL lock, runs the BCLK/SCLK align trainer and then
// the bit-align stage, each under a timeout, retrying up to MAX_RETRY times before
// latching a training error. All outputs are registered.
// Optional feature: define RX_TRAIN_SEQ_LOCK_MONITOR_EN to restart training from
// lock wait whenever PLL lock drops in CLK_TRAIN, BIT_TRAIN or DONE.
// Ports:
//   sclk_i                  sole clock, rising edge
//   reset_i                 asynchronous active-high reset
//   pll_lock_i              PLL lock, synchronous to sclk_i
//   bclksclk_train_start_o  level request to the align trainer (high in CLK_TRAIN)
//   bclksclk_train_done_i   align trainer done
//   icb_clk_algn_err_i      align trainer error
//   clk_algn_rstrt_o        one-cycle restart pulse to the align trainer
//   bit_algn_start_o        level request to bit-align (high in BIT_TRAIN)
//   bit_algn_done_i         bit-align done
//   bit_algn_err_i          bit-align error
//   train_retry_i           user restart pulse
//   train_done_o            lane trained (sticky)
//   train_err_o             retries exhausted (sticky)
//   train_state_o           current state encoding
//   retry_cnt_o             failures since last clear, saturating
module rx_train_sequencer
    import rx_train_seq_pkg::*;
#(
    parameter int LOCK_WAIT_CNT_WIDTH = 8,
    parameter int TIMEOUT_CNT_WIDTH   = 16,
    parameter int MAX_RETRY           = 3
) (
    input  logic                   sclk_i,
    input  logic                   reset_i,
    input  logic                   pll_lock_i,
    output logic                   bclksclk_train_start_o,
    input  logic                   bclksclk_train_done_i,
    input  logic                   icb_clk_algn_err_i,
    output logic                   clk_algn_rstrt_o,
    output logic                   bit_algn_start_o,
    input  logic                   bit_algn_done_i,
    input  logic                   bit_algn_err_i,
    input  logic                   train_retry_i,
    output logic                   train_done_o,
    output logic                   train_err_o,
    output logic [2:0]             train_state_o,
    output logic [RETRY_CNT_W-1:0] retry_cnt_o
);

    localparam int TMR_W = (LOCK_WAIT_CNT_WIDTH > TIMEOUT_CNT_WIDTH) ?
                           LOCK_WAIT_CNT_WIDTH : TIMEOUT_CNT_WIDTH;

    // Lock wait leaves on the locked sample that finds the counter already at
    // zero, so loading 2^W-2 makes that the (2^W-1)th consecutive locked cycle.
    localparam logic [TMR_W-1:0] LOCK_LOAD    = TMR_W'((2 ** LOCK_WAIT_CNT_WIDTH) - 2);
    // Phase timer spans 2^W cycles: values 2^W-1 down to 0, expiry judged at 0.
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'((2 ** TIMEOUT_CNT_WIDTH) - 1);
    localparam logic [RETRY_CNT_W-1:0] MAX_RETRY_C =
        (MAX_RETRY >= 15) ? RETRY_CNT_SAT : RETRY_CNT_W'(MAX_RETRY);

    state_t                 state_q, state_d;
    logic [RETRY_CNT_W-1:0] retry_cnt_q, retry_cnt_d;
    logic                   rstrt_d;
    logic                   phase_fail;
    logic                   lock_lost;
    logic                   tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0]       tmr_load_val;

`ifdef RX_TRAIN_SEQ_LOCK_MONITOR_EN
    assign lock_lost = ~pll_lock_i;
`else
    assign lock_lost = 1'b0;
`endif

    rx_train_seq_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk_i      (sclk_i),
        .rst_i      (reset_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        retry_cnt_d  = retry_cnt_q;
        rstrt_d      = 1'b0;
        phase_fail   = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = LOCK_LOAD;
        tmr_dec      = 1'b0;

        if (train_retry_i && (state_q != ST_IDLE)) begin
            // User restart beats every other transition, including a done
            // or error arriving in the same cycle.
            state_d     = ST_LOCK_WAIT;
            retry_cnt_d = '0;
            rstrt_d     = 1'b1;
            tmr_load    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_LOCK_WAIT;
                    tmr_load = 1'b1;
                end
                ST_LOCK_WAIT: begin
                    if (!pll_lock_i) begin
                        tmr_load = 1'b1;
                    end else if (tmr_zero) begin
                        state_d      = ST_CLK_TRAIN;
                        tmr_load     = 1'b1;
                        tmr_load_val = TIMEOUT_LOAD;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_CLK_TRAIN: begin
                    if (lock_lost) begin
                        state_d  = ST_LOCK_WAIT;
                        rstrt_d  = 1'b1;
                        tmr_load = 1'b1;
                    end else if (icb_clk_algn_err_i) begin
                        phase_fail = 1'b1;
                    end else if (bclksclk_train_done_i) begin
                        state_d      = ST_BIT_TRAIN;
                        tmr_load     = 1'b1;
                        tmr_load_val = TIMEOUT_LOAD;
                    end else if (tmr_zero) begin
                        phase_fail = 1'b1;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_BIT_TRAIN: begin
                    if (lock_lost) begin
                        state_d  = ST_LOCK_WAIT;
                        rstrt_d  = 1'b1;
                        tmr_load = 1'b1;
                    end else if (bit_algn_err_i) begin
                        phase_fail = 1'b1;
                    end else if (bit_algn_done_i) begin
                        state_d = ST_DONE;
                    end else if (tmr_zero) begin
                        phase_fail = 1'b1;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (lock_lost) begin
                        state_d  = ST_LOCK_WAIT;
                        rstrt_d  = 1'b1;
                        tmr_load = 1'b1;
                    end
                end
                ST_RETRY: begin
                    state_d  = ST_LOCK_WAIT;
                    tmr_load = 1'b1;
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (phase_fail) begin
                if (retry_cnt_q < MAX_RETRY_C) begin
                    retry_cnt_d = (retry_cnt_q == RETRY_CNT_SAT) ? retry_cnt_q
                                                                 : retry_cnt_q + 1'b1;
                    state_d     = ST_RETRY;
                    rstrt_d     = 1'b1;
                end else begin
                    state_d = ST_FAIL;
                end
            end
        end
    end

    // Outputs are registered from the next state so they align with train_state_o.
    always_ff @(posedge sclk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q                <= ST_IDLE;
            retry_cnt_q            <= '0;
            bclksclk_train_start_o <= 1'b0;
            bit_algn_start_o       <= 1'b0;
            train_done_o           <= 1'b0;
            train_err_o            <= 1'b0;
            clk_algn_rstrt_o       <= 1'b0;
        end else begin
            state_q                <= state_d;
            retry_cnt_q            <= retry_cnt_d;
            bclksclk_train_start_o <= (state_d == ST_CLK_TRAIN);
            bit_algn_start_o       <= (state_d == ST_BIT_TRAIN);
            train_done_o           <= (state_d == ST_DONE);
            train_err_o            <= (state_d == ST_FAIL);
            clk_algn_rstrt_o       <= rstrt_d;
        end
    end

    assign train_state_o = state_q;
    assign retry_cnt_o   = retry_cnt_q;

endmodule

// File: tb/tb_rx_train_sequencer.sv
// tb/tb_rx_train_sequencer.sv - self-checking bench for rx_train_sequencer
module tb_rx_train_sequencer;

    localparam int LW        = 4;
    localparam int TW        = 6;
    localparam int MR        = 2;
    localparam int LOCK_RUN  = (2 ** LW) - 1;
    localparam int PHASE_MAX = 2 ** TW;

    logic       sclk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       clk_done = 1'b0, clk_err = 1'b0;
    logic       bit_done = 1'b0, bit_err = 1'b0;
    logic       train_retry = 1'b0;
    logic       start_o, rstrt_o, bit_start_o, done_o, err_o;
    logic [2:0] state_o;
    logic [3:0] cnt_o;

    int vectors = 0;
    int errors  = 0;
    int rstrt_total = 0;

    rx_train_sequencer #(
        .LOCK_WAIT_CNT_WIDTH (LW),
        .TIMEOUT_CNT_WIDTH   (TW),
        .MAX_RETRY           (MR)
    ) dut (
        .sclk_i                 (sclk),
        .reset_i                (reset),
        .pll_lock_i             (pll_lock),
        .bclksclk_train_start_o (start_o),
        .bclksclk_train_done_i  (clk_done),
        .icb_clk_algn_err_i     (clk_err),
        .clk_algn_rstrt_o       (rstrt_o),
        .bit_algn_start_o       (bit_start_o),
        .bit_algn_done_i        (bit_done),
        .bit_algn_err_i         (bit_err),
        .train_retry_i          (train_retry),
        .train_done_o           (done_o),
        .train_err_o            (err_o),
        .train_state_o          (state_o),
        .retry_cnt_o            (cnt_o)
    );

    always #5 sclk = ~sclk;

    always @(negedge sclk) begin
        if (rstrt_o === 1'b1) rstrt_total <= rstrt_total + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; pll_lock = 1'b0; clk_done = 1'b0; clk_err = 1'b0;
        bit_done = 1'b0; bit_err = 1'b0; train_retry = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (!ok && n < budget) begin
            tick();
            n++;
            ok = (state_o === s);
        end
    endtask

    // Assert the stage's done so it is sampled d cycles after phase entry; counts start-high samples.
    task automatic phase_done(input bit is_bit, input int d, output int hi);
        hi = 0;
        for (int k = 1; k <= d; k++) begin
            if ((is_bit ? bit_start_o : start_o) === 1'b1) hi++;
            if (k == d) begin
                if (is_bit) bit_done = 1'b1; else clk_done = 1'b1;
            end
            tick();
        end
        clk_done = 1'b0; bit_done = 1'b0;
    endtask

    task automatic test_reset();
        int n; bit ok;
        reset = 1'b1;
        tick(); tick();
        vectors++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        vectors++; if (start_o !== 1'b0) begin errors++; $display("FAIL reset_clk_start: got %b expected 0", start_o); end
        vectors++; if (bit_start_o !== 1'b0) begin errors++; $display("FAIL reset_bit_start: got %b expected 0", bit_start_o); end
        vectors++; if (rstrt_o !== 1'b0) begin errors++; $display("FAIL reset_rstrt: got %b expected 0", rstrt_o); end
        vectors++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
        vectors++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
        vectors++; if (cnt_o !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt_o); end
        reset = 1'b0; pll_lock = 1'b1;
        tick();
        vectors++; if (state_o !== 3'd1) begin errors++; $display("FAIL reset_exit_state: got %0d expected 1", state_o); end
        wait_state(3'd2, 40, n, ok);
        vectors++; if (!ok || n != LOCK_RUN) begin errors++; $display("FAIL lock_wait_len: got %0d (reached %0d) expected %0d", n, ok, LOCK_RUN); end
    endtask

    task automatic test_nominal();
        int d1, d2, n, hi, base; bit ok;
        for (int it = 0; it < 5; it++) begin
            d1 = (it == 0) ? 10 : (it == 1) ? PHASE_MAX : $urandom_range(1, PHASE_MAX);
            d2 = (it == 0) ? 20 : (it == 1) ? 1 : $urandom_range(1, PHASE_MAX);
            do_reset(); pll_lock = 1'b1; tick();
            base = rstrt_total;
            wait_state(3'd2, 40, n, ok);
            vectors++; if (!ok || n != LOCK_RUN) begin errors++; $display("FAIL nom_lock_len: got %0d expected %0d", n, LOCK_RUN); end
            phase_done(1'b0, d1, hi);
            vectors++; if (hi != d1 || start_o !== 1'b0) begin errors++; $display("FAIL nom_clk_start_len: got %0d expected %0d", hi, d1); end
            vectors++; if (state_o !== 3'd3) begin errors++; $display("FAIL nom_bit_entry: got %0d expected 3", state_o); end
            phase_done(1'b1, d2, hi);
            vectors++; if (hi != d2 || bit_start_o !== 1'b0) begin errors++; $display("FAIL nom_bit_start_len: got %0d expected %0d", hi, d2); end
            vectors++; if (state_o !== 3'd4 || done_o !== 1'b1 || cnt_o !== 4'd0) begin errors++; $display("FAIL nom_done: got state %0d done %b cnt %0d expected 4 1 0", state_o, done_o, cnt_o); end
            repeat (5) tick();
            vectors++; if (done_o !== 1'b1 || state_o !== 3'd4) begin errors++; $display("FAIL nom_done_sticky: got done %b state %0d expected 1 4", done_o, state_o); end
            vectors++; if (rstrt_total != base) begin errors++; $display("FAIL nom_no_rstrt: got %0d pulses expected 0", rstrt_total - base); end
        end
    endtask

    task automatic test_lock_glitch();
        bit pat[128];
        int exp_j, got, run;
        for (int it = 0; it < 4; it++) begin
            for (int j = 0; j < 128; j++)
                pat[j] = (j >= 48) ? 1'b1 : (it == 0) ? (j != 11) : ($urandom_range(0, 4) != 0);
            run = 0; exp_j = -1;
            for (int j = 1; j < 128; j++) begin
                run = pat[j] ? run + 1 : 0;
                if (run == LOCK_RUN && exp_j < 0) exp_j = j;
            end
            do_reset(); pll_lock = 1'b1; tick();
            got = -1;
            for (int j = 1; j < 128 && got < 0; j++) begin
                pll_lock = pat[j];
                tick();
                if (state_o !== 3'd1) got = j;
            end
            pll_lock = 1'b1;
            vectors++; if (got != exp_j || state_o !== 3'd2) begin errors++; $display("FAIL glitch_entry: got cycle %0d state %0d expected cycle %0d state 2", got, state_o, exp_j); end
            if (it == 0) begin
                vectors++; if (got != 26) begin errors++; $display("FAIL glitch_fixed: got cycle %0d expected 26", got); end
            end
        end
    endtask

    task automatic test_timeout_exhaust();
        int n, base; bit ok;
        do_reset(); pll_lock = 1'b1; tick();
        base = rstrt_total;
        for (int a = 1; a <= 3; a++) begin
            wait_state(3'd2, 40, n, ok);
            vectors++; if (!ok || n != LOCK_RUN) begin errors++; $display("FAIL to_lock_len: got %0d expected %0d", n, LOCK_RUN); end
            n = 0;
            while (state_o === 3'd2 && n < 200) begin tick(); n++; end
            vectors++; if (n != PHASE_MAX) begin errors++; $display("FAIL to_phase_len: got %0d expected %0d", n, PHASE_MAX); end
            if (a < 3) begin
                vectors++; if (state_o !== 3'd5 || rstrt_o !== 1'b1 || cnt_o !== 4'(a)) begin errors++; $display("FAIL to_retry: got state %0d rstrt %b cnt %0d expected 5 1 %0d", state_o, rstrt_o, cnt_o, a); end
                tick();
                vectors++; if (state_o !== 3'd1 || rstrt_o !== 1'b0) begin errors++; $display("FAIL to_retry_exit: got state %0d rstrt %b expected 1 0", state_o, rstrt_o); end
            end else begin
                vectors++; if (state_o !== 3'd6 || err_o !== 1'b1 || cnt_o !== 4'(MR) || rstrt_o !== 1'b0) begin errors++; $display("FAIL to_fail: got state %0d err %b cnt %0d rstrt %b expected 6 1 %0d 0", state_o, err_o, cnt_o, rstrt_o, MR); end
            end
        end
        repeat (5) tick();
        vectors++; if (err_o !== 1'b1 || state_o !== 3'd6) begin errors++; $display("FAIL to_fail_sticky: got err %b state %0d expected 1 6", err_o, state_o); end
        vectors++; if (rstrt_total - base != 2) begin errors++; $display("FAIL to_pulse_count: got %0d expected 2", rstrt_total - base); end
    endtask

    task automatic test_recovery();
        int n, hi, base; bit ok;
        base = rstrt_total;
        train_retry = 1'b1; tick(); train_retry = 1'b0;
        vectors++; if (state_o !== 3'd1 || rstrt_o !== 1'b1 || cnt_o !== 4'd0 || err_o !== 1'b0) begin errors++; $display("FAIL rec_retry: got state %0d rstrt %b cnt %0d err %b expected 1 1 0 0", state_o, rstrt_o, cnt_o, err_o); end
        tick();
        vectors++; if (rstrt_o !== 1'b0) begin errors++; $display("FAIL rec_pulse_width: got %b expected 0", rstrt_o); end
        wait_state(3'd2, 40, n, ok);
        phase_done(1'b0, 5, hi);
        vectors++; if (state_o !== 3'd3 || bit_start_o !== 1'b1) begin errors++; $display("FAIL rec_bit_entry: got state %0d bit_start %b expected 3 1", state_o, bit_start_o); end
        repeat (3) tick();
        reset = 1'b1; #1;
        vectors++; if ({start_o, bit_start_o, rstrt_o, done_o, err_o} !== 5'b0 || state_o !== 3'd0 || cnt_o !== 4'd0) begin errors++; $display("FAIL rec_async_reset: got flags %b state %0d cnt %0d expected 0 0 0", {start_o, bit_start_o, rstrt_o, done_o, err_o}, state_o, cnt_o); end
        tick(); reset = 1'b0; tick();
        vectors++; if (state_o !== 3'd1 || rstrt_o !== 1'b0) begin errors++; $display("FAIL rec_after_reset: got state %0d rstrt %b expected 1 0", state_o, rstrt_o); end
        vectors++; if (rstrt_total - base != 1) begin errors++; $display("FAIL rec_pulse_count: got %0d expected 1", rstrt_total - base); end
    endtask

    task automatic test_simultaneous();
        int n, hi; bit ok;
        do_reset(); pll_lock = 1'b1; tick();
        wait_state(3'd2, 40, n, ok);
        repeat (3) tick();
        clk_err = 1'b1; clk_done = 1'b1; tick(); clk_err = 1'b0; clk_done = 1'b0;
        vectors++; if (state_o !== 3'd5 || cnt_o !== 4'd1 || rstrt_o !== 1'b1) begin errors++; $display("FAIL sim_err_wins: got state %0d cnt %0d rstrt %b expected 5 1 1", state_o, cnt_o, rstrt_o); end
        wait_state(3'd2, 40, n, ok);
        vectors++; if (!ok || n != LOCK_RUN + 1) begin errors++; $display("FAIL sim_relock_len: got %0d expected %0d", n, LOCK_RUN + 1); end
        phase_done(1'b0, PHASE_MAX, hi);
        vectors++; if (state_o !== 3'd3 || hi != PHASE_MAX || cnt_o !== 4'd1) begin errors++; $display("FAIL sim_done_at_expiry: got state %0d hi %0d cnt %0d expected 3 %0d 1", state_o, hi, cnt_o, PHASE_MAX); end
        phase_done(1'b1, 7, hi);
        vectors++; if (state_o !== 3'd4 || done_o !== 1'b1 || cnt_o !== 4'd1) begin errors++; $display("FAIL sim_done: got state %0d done %b cnt %0d expected 4 1 1", state_o, done_o, cnt_o); end
    endtask

    task automatic test_lock_monitor();
        pll_lock = 1'b0; tick(); pll_lock = 1'b1;
`ifdef RX_TRAIN_SEQ_LOCK_MONITOR_EN
        vectors++; if (state_o !== 3'd1 || done_o !== 1'b0 || rstrt_o !== 1'b1 || cnt_o !== 4'd1) begin errors++; $display("FAIL mon_drop: got state %0d done %b rstrt %b cnt %0d expected 1 0 1 1", state_o, done_o, rstrt_o, cnt_o); end
`else
        vectors++; if (state_o !== 3'd4 || done_o !== 1'b1 || rstrt_o !== 1'b0 || cnt_o !== 4'd1) begin errors++; $display("FAIL mon_ignored: got state %0d done %b rstrt %b cnt %0d expected 4 1 0 1", state_o, done_o, rstrt_o, cnt_o); end
`endif
        tick();
        vectors++; if (rstrt_o !== 1'b0) begin errors++; $display("FAIL mon_pulse_width: got %b expected 0", rstrt_o); end
    endtask

    task automatic test_retry_override();
        int n; bit ok;
        do_reset(); pll_lock = 1'b1; tick();
        wait_state(3'd2, 40, n, ok);
        clk_err = 1'b1; tick(); clk_err = 1'b0;
        vectors++; if (state_o !== 3'd5 || cnt_o !== 4'd1) begin errors++; $display("FAIL ovr_first_fail: got state %0d cnt %0d expected 5 1", state_o, cnt_o); end
        wait_state(3'd2, 40, n, ok);
        repeat (2) tick();
        clk_done = 1'b1; train_retry = 1'b1; tick(); clk_done = 1'b0; train_retry = 1'b0;
        vectors++; if (state_o !== 3'd1 || cnt_o !== 4'd0 || rstrt_o !== 1'b1 || start_o !== 1'b0) begin errors++; $display("FAIL ovr_retry_wins: got state %0d cnt %0d rstrt %b start %b expected 1 0 1 0", state_o, cnt_o, rstrt_o, start_o); end
    endtask

    task automatic test_bit_err();
        int n, hi, d; bit ok;
        do_reset(); pll_lock = 1'b1; tick();
        for (int a = 1; a <= 3; a++) begin
            wait_state(3'd2, 40, n, ok);
            vectors++; if (!ok) begin errors++; $display("FAIL be_reach_clk: got state %0d expected 2", state_o); end
            phase_done(1'b0, $urandom_range(1, PHASE_MAX), hi);
            d = $urandom_range(1, PHASE_MAX);
            repeat (d - 1) tick();
            bit_err = 1'b1;
            if (a == 2) bit_done = 1'b1;
            tick();
            bit_err = 1'b0; bit_done = 1'b0;
            if (a < 3) begin
                vectors++; if (state_o !== 3'd5 || cnt_o !== 4'(a) || done_o !== 1'b0) begin errors++; $display("FAIL be_retry: got state %0d cnt %0d done %b expected 5 %0d 0", state_o, cnt_o, done_o, a); end
            end else begin
                vectors++; if (state_o !== 3'd6 || err_o !== 1'b1 || done_o !== 1'b0 || cnt_o !== 4'(MR)) begin errors++; $display("FAIL be_fail: got state %0d err %b done %b cnt %0d expected 6 1 0 %0d", state_o, err_o, done_o, cnt_o, MR); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lock_glitch();
        test_timeout_exhaust();
        test_recovery();
        test_simultaneous();
        test_lock_monitor();
        test_retry_override();
        test_bit_err();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
